// File: rtl/temp_pkg.sv
// Shared types and helpers for the temperature sensor datapath.
package temp_pkg;

  localparam int TEMP_W = 13;

  typedef logic signed [15:0] temp_t;

  typedef enum logic [0:0] {FILL, RUN} avg_state_t;

  // Sign-extend the low 'bits' bits of a raw sensor word to a full temp_t.
  function automatic temp_t temp_sext(input logic [15:0] word, input int bits);
    temp_t t;
    t = temp_t'(word << (16 - bits));
    return t >>> (16 - bits);
  endfunction

endpackage

// File: rtl/temp_moving_avg.sv
// Moving average over a 2^AVG_LOG2 window of temperature samples, with
// min/max tracking since the last clear and a valid/ready result port.
module temp_moving_avg #(
  parameter int AVG_LOG2 = 4,
  parameter int TEMP_W   = temp_pkg::TEMP_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        fix_temp_tvalid,
  input  logic [15:0] fix_temp_tdata,
  output logic        avg_tvalid,
  input  logic        avg_tready,
  output logic [15:0] avg_tdata,
  output logic [15:0] min_tdata,
  output logic [15:0] max_tdata,
  output logic        window_full,
  output logic        dropped
);
  import temp_pkg::*;

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 16 + AVG_LOG2;

  typedef logic signed [SUM_W-1:0] sum_t;

  localparam temp_t MIN_INIT = 16'sh0FFF;
  localparam temp_t MAX_INIT = -16'sh1000;

  // Round half toward +inf, then divide by the window depth.
  function automatic temp_t round_avg(input sum_t s);
    sum_t r;
    r = (s + sum_t'(DEPTH / 2)) >>> AVG_LOG2;
    return r[15:0];
  endfunction

  temp_t                ring_q [DEPTH];
  sum_t                 sum_q;
  sum_t                 sum_d;
  logic [AVG_LOG2-1:0]  wptr_q;
  avg_state_t           state_q;
  avg_state_t           state_d;

  logic                 res_vld_p0;
  logic                 samp_vld_p0;
  temp_t                samp_p0;

  logic                 avg_vld_q;
  temp_t                avg_q;
  temp_t                min_q;
  temp_t                max_q;
  logic                 seen_q;
  logic                 dropped_q;

  temp_t                sample_s;
  temp_t                old_s;
  logic                 strobe;
  logic                 last_fill;

  assign strobe    = fix_temp_tvalid & ~clear;
  assign sample_s  = temp_sext(fix_temp_tdata, TEMP_W);
  assign old_s     = ring_q[wptr_q];
  assign sum_d     = sum_q + sum_t'(sample_s) - sum_t'(old_s);
  assign last_fill = (state_q == FILL) && (wptr_q == AVG_LOG2'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)                  state_d = FILL;
    else if (strobe && last_fill) state_d = RUN;
  end

  always_comb begin
    window_full = (state_q == RUN);
  end

  // Stage 0: accumulate into the ring/sum and note whether a result is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      sum_q       <= '0;
      wptr_q      <= '0;
      res_vld_p0  <= 1'b0;
      samp_vld_p0 <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      sum_q       <= '0;
      wptr_q      <= '0;
      res_vld_p0  <= 1'b0;
      samp_vld_p0 <= 1'b0;
    end else begin
      if (strobe) begin
        ring_q[wptr_q] <= sample_s;
        sum_q          <= sum_d;
        wptr_q         <= wptr_q + AVG_LOG2'(1);
      end
      res_vld_p0  <= strobe && ((state_q == RUN) || last_fill);
      samp_vld_p0 <= strobe;
    end
  end

  always_ff @(posedge clk) begin
    if (strobe) samp_p0 <= sample_s;
  end

  // Stage 1: register the average, run the output handshake, update min/max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_vld_q <= 1'b0;
      avg_q     <= '0;
      dropped_q <= 1'b0;
      min_q     <= MIN_INIT;
      max_q     <= MAX_INIT;
      seen_q    <= 1'b0;
    end else if (clear) begin
      avg_vld_q <= 1'b0;
      dropped_q <= 1'b0;
      min_q     <= MIN_INIT;
      max_q     <= MAX_INIT;
      seen_q    <= 1'b0;
    end else begin
      if (res_vld_p0) begin
        avg_q     <= round_avg(sum_q);
        avg_vld_q <= 1'b1;
        if (avg_vld_q && !avg_tready) dropped_q <= 1'b1;
      end else if (avg_vld_q && avg_tready) begin
        avg_vld_q <= 1'b0;
      end
      if (samp_vld_p0) begin
        if (!seen_q || (samp_p0 < min_q)) min_q <= samp_p0;
        if (!seen_q || (samp_p0 > max_q)) max_q <= samp_p0;
        seen_q <= 1'b1;
      end
    end
  end

  // min/max read as zero until a sample has been seen since reset/clear.
  assign avg_tvalid = avg_vld_q;
  assign avg_tdata  = avg_q;
  assign dropped    = dropped_q;
  assign min_tdata  = seen_q ? min_q : '0;
  assign max_tdata  = seen_q ? max_q : '0;

endmodule

// File: tb/tb_temp_moving_avg.sv
// Randomized bench for temp_moving_avg against a queue-based reference model.
module tb_temp_moving_avg;

  localparam int LOG2  = 4;
  localparam int DEPTH = 1 << LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        fix_temp_tvalid = 1'b0;
  logic [15:0] fix_temp_tdata = '0;
  logic        avg_tvalid;
  logic        avg_tready = 1'b1;
  logic [15:0] avg_tdata;
  logic [15:0] min_tdata;
  logic [15:0] max_tdata;
  logic        window_full;
  logic        dropped;

  temp_moving_avg #(.AVG_LOG2(LOG2), .TEMP_W(13)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .fix_temp_tvalid(fix_temp_tvalid), .fix_temp_tdata(fix_temp_tdata),
    .avg_tvalid(avg_tvalid), .avg_tready(avg_tready), .avg_tdata(avg_tdata),
    .min_tdata(min_tdata), .max_tdata(max_tdata),
    .window_full(window_full), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int win[$];
  int minv, maxv;
  int exp_drop = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int to_temp(input logic [15:0] w);
    int v;
    v = int'(w[12:0]);
    if (v >= 4096) v -= 8192;
    return v;
  endfunction

  function automatic int model_avg();
    int s, n, q;
    s = 0;
    for (int i = win.size() - DEPTH; i < win.size(); i++) s += win[i];
    n = s + DEPTH / 2;
    q = n / DEPTH;
    if ((n % DEPTH != 0) && (n < 0)) q -= 1;
    return q;
  endfunction

  task automatic model_clear();
    win.delete();
    exp_drop = 0;
  endtask

  task automatic model_push(input logic [15:0] d);
    int v;
    v = to_temp(d);
    if (win.size() == 0) begin
      minv = v;
      maxv = v;
    end else begin
      if (v < minv) minv = v;
      if (v > maxv) maxv = v;
    end
    win.push_back(v);
  endtask

  task automatic strobe(input logic [15:0] d);
    @(negedge clk);
    fix_temp_tvalid = 1'b1;
    fix_temp_tdata  = d;
    @(negedge clk);
    fix_temp_tvalid = 1'b0;
    model_push(d);
  endtask

  task automatic step(input logic [15:0] d);
    bit res;
    strobe(d);
    chk("early_vld", int'(avg_tvalid), 0);
    @(negedge clk);
    res = (win.size() >= DEPTH);
    chk("avg_vld", int'(avg_tvalid), int'(res));
    if (res) chk("avg_data", int'($signed(avg_tdata)), model_avg());
    chk("wfull", int'(window_full), int'(res));
    chk("min", int'($signed(min_tdata)), minv);
    chk("max", int'($signed(max_tdata)), maxv);
    chk("dropped", int'(dropped), exp_drop);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, int'(avg_tvalid), 0);
    chk({tag, "_avg"}, int'(avg_tdata), 0);
    chk({tag, "_min"}, int'(min_tdata), 0);
    chk({tag, "_max"}, int'(max_tdata), 0);
    chk({tag, "_wfull"}, int'(window_full), 0);
    chk({tag, "_drop"}, int'(dropped), 0);
  endtask

  function automatic logic [15:0] rnd_word();
    return 16'($urandom);
  endfunction

  initial begin
    int r1, r2;
    logic [15:0] d;

    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();

    for (int i = 0; i < DEPTH; i++) step(16'h0190);
    chk("t1_avg", int'(avg_tdata), 16'h0190);

    do_clear();
    for (int i = 0; i < DEPTH; i++) step(16'h1F60);
    chk("t2_avg", int'(avg_tdata), 16'hFF60);
    chk("t2_min", int'(min_tdata), 16'hFF60);

    do_clear();
    for (int i = 0; i < 8; i++) step(16'h0190);
    for (int i = 0; i < 8; i++) step(16'h0191);
    chk("t3_avg", int'(avg_tdata), 16'h0191);
    step(16'h0190);

    // Backpressure: two results land while the consumer stalls.
    @(negedge clk);
    avg_tready = 1'b0;
    strobe(rnd_word());
    r1 = model_avg();
    @(negedge clk);
    chk("bp1_vld", int'(avg_tvalid), 1);
    chk("bp1_avg", int'($signed(avg_tdata)), r1);
    chk("bp1_drop", int'(dropped), 0);
    strobe(rnd_word());
    r2 = model_avg();
    @(negedge clk);
    chk("bp2_vld", int'(avg_tvalid), 1);
    chk("bp2_avg", int'($signed(avg_tdata)), r2);
    chk("bp2_drop", int'(dropped), 1);
    avg_tready = 1'b1;
    @(negedge clk);
    avg_tready = 1'b0;
    chk("bp3_vld", int'(avg_tvalid), 0);
    chk("bp3_drop", int'(dropped), 1);
    @(negedge clk);
    avg_tready = 1'b1;
    chk("bp4_drop", int'(dropped), 1);

    // Clear coincident with a strobe discards that sample.
    @(negedge clk);
    clear = 1'b1;
    fix_temp_tvalid = 1'b1;
    fix_temp_tdata = 16'h07FF;
    @(negedge clk);
    clear = 1'b0;
    fix_temp_tvalid = 1'b0;
    model_clear();
    chk("clr_wfull", int'(window_full), 0);
    chk("clr_vld", int'(avg_tvalid), 0);
    chk("clr_drop", int'(dropped), 0);
    @(negedge clk);
    chk("clr_vld2", int'(avg_tvalid), 0);
    for (int i = 0; i < DEPTH; i++) step(rnd_word());

    // Reset asserted while a result is still in flight.
    @(negedge clk);
    fix_temp_tvalid = 1'b1;
    fix_temp_tdata = rnd_word();
    @(negedge clk);
    fix_temp_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    chk("rst_hold_vld", int'(avg_tvalid), 0);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < DEPTH; i++) step(rnd_word());

    // Random run with extreme values mixed in.
    for (int i = 0; i < 48; i++) begin
      case ($urandom_range(0, 5))
        0: d = 16'h0FFF;
        1: d = 16'h1000;
        default: d = rnd_word();
      endcase
      step(d);
      if (i == 30) do_clear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
